// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings, iteration count and execute-stage op codes for the divider.
package div_unit_pkg;
   localparam int DIV_ITERATIONS = 32;
   localparam logic [7:0] EXE_DIV_OP = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(parameter int DATA_W = 32);
   logic start, signed_div, annul, busy, ready;
   logic [DATA_W-1:0] opdata1, opdata2;
   logic [2*DATA_W-1:0] result;
   modport master (output start, signed_div, opdata1, opdata2, annul, input busy, ready, result);
   modport slave (input start, signed_div, opdata1, opdata2, annul, output busy, ready, result);
endinterface

// File: rtl/div_unit_sign_fix.sv
// div_unit_sign_fix: conditional two's-complement negation of a value pair.
// Negation is its own inverse, so one block serves both abs-in and signed-out.
module div_unit_sign_fix #(parameter int W = 32) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         neg_a,
   input  logic         neg_b,
   output logic [W-1:0] y_a,
   output logic [W-1:0] y_b
);
   assign y_a = neg_a ? -a : a;
   assign y_b = neg_b ? -b : b;
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU returning {remainder, quotient}.
// Define DIV_FAST_PATH_EN to short-circuit operations where |dividend| < |divisor|.
module div_unit
   import div_unit_pkg::*;
#(parameter int DATA_W = DIV_ITERATIONS) (
   input logic        clk,
   input logic        resetn,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(DATA_W);
   div_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
   logic qneg_q, qneg_d, rneg_q, rneg_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic ready_q, ready_d, busy_q, busy_d;
   logic sg1, sg2, ge;
   logic [DATA_W-1:0] abs1, abs2, q_next, r_next, q_fix, r_fix;
   logic [DATA_W:0] shifted;
   logic [DATA_W+1:0] trial;
   assign sg1 = bus.signed_div & bus.opdata1[DATA_W-1];
   assign sg2 = bus.signed_div & bus.opdata2[DATA_W-1];
   div_unit_sign_fix #(.W(DATA_W)) u_abs (
      .a(bus.opdata1), .b(bus.opdata2), .neg_a(sg1), .neg_b(sg2), .y_a(abs1), .y_b(abs2));
   div_unit_sign_fix #(.W(DATA_W)) u_fix (
      .a(q_next), .b(r_next), .neg_a(qneg_q), .neg_b(rneg_q), .y_a(q_fix), .y_b(r_fix));
   // Partial remainder stays below the divisor, so a restored value always fits in DATA_W bits.
   assign shifted = {rem_q, dvd_q[DATA_W-1]};
   assign trial = {1'b0, shifted} - {2'b0, dvs_q};
   assign ge = ~trial[DATA_W+1];
   assign r_next = ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
   assign q_next = {dvd_q[DATA_W-2:0], ge};
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      result_d = result_q;
      unique case (state_q)
         DIV_IDLE: if (bus.start && !bus.annul) begin
            qneg_d = sg1 ^ sg2;
            rneg_d = sg1;
            dvd_d = abs1;
            dvs_d = abs2;
            rem_d = '0;
            cnt_d = '0;
            state_d = DIV_BUSY;
            if (bus.opdata2 == '0) begin
               state_d = DIV_DONE;
               result_d = '0;
            end
`ifdef DIV_FAST_PATH_EN
            else if (abs1 < abs2) begin
               state_d = DIV_DONE;
               result_d = {bus.opdata1, {DATA_W{1'b0}}};
            end
`else
`endif
         end
         DIV_BUSY: begin
            rem_d = r_next;
            dvd_d = q_next;
            cnt_d = cnt_q + 1'b1;
            if (bus.annul) state_d = DIV_IDLE;
            else if (cnt_q == CW'(DATA_W-1)) begin
               state_d = DIV_DONE;
               result_d = {r_fix, q_fix};
            end
         end
         default: state_d = DIV_IDLE;
      endcase
      busy_d = state_q != DIV_IDLE;
      ready_d = state_q == DIV_DONE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= DIV_IDLE;
         cnt_q <= '0;
         rem_q <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         result_q <= '0;
         ready_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         result_q <= result_d;
         ready_q <= ready_d;
         busy_q <= busy_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.ready = ready_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven divider bench with a result scoreboard and hand-written annul/reset sequences.
module tb_div_unit;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;
   div_unit_if #(.DATA_W(32)) dut_if ();
   div_unit #(.DATA_W(32)) dut (.clk(clk), .resetn(resetn), .bus(dut_if));
`ifdef DIV_FAST_PATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   typedef struct {
      logic        sdiv;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      bit          fast;
   } vec_t;
   vec_t v[12];
   int compared = 0;
   int mismatched = 0;
   int ready_seen = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input logic [31:0] b, input bit fast);
      return (b == 0 || (FAST && fast)) ? 1 : 33;
   endfunction

   always @(negedge clk) begin
      if (resetn && dut_if.ready === 1'b1) begin
         ready_seen++;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_ready: got result %h with no request outstanding", dut_if.result);
         end else check("result", dut_if.result, exp_q.pop_front());
      end
   end

   task automatic run_op(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int lat, input bit poke);
      int n;
      bit busy_ok;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.signed_div = sdiv;
      dut_if.opdata1 = a;
      dut_if.opdata2 = b;
      exp_q.push_back(res);
      @(posedge clk);
      #1 dut_if.start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (n < 40) begin
         @(posedge clk);
         #1 n++;
         if (poke && n == 5) begin
            dut_if.start = 1'b1;
            dut_if.opdata1 = 32'hDEAD;
            dut_if.opdata2 = 32'd3;
         end else dut_if.start = 1'b0;
         if (!dut_if.busy) busy_ok = 1'b0;
         if (dut_if.ready) break;
      end
      check("latency", 64'(n), 64'(lat));
      check("busy_during", 64'(busy_ok), 64'd1);
      @(posedge clk);
      #1 check("busy_after", 64'(dut_if.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      logic [31:0] a, b;
      v[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},        1'b0};
      v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  1'b0};
      v[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,        32'hFFFFFFFD},  1'b0};
      v[3]  = '{1'b0, 32'h1234,       32'd0,          64'd0,                          1'b0};
      v[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,        32'h80000000},  1'b0};
      v[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,        32'hFFFFFFFF},  1'b0};
      v[6]  = '{1'b0, 32'd3,          32'd9,          {32'd3,        32'd0},         1'b1};
      v[7]  = '{1'b1, 32'hFFFFFFFD,   32'd9,          {32'hFFFFFFFD, 32'd0},         1'b1};
      v[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,        32'd1},         1'b0};
      v[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},        1'b0};
      v[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},         1'b1};
      v[11] = '{1'b1, 32'd0,          32'd5,          {32'd0,        32'd0},         1'b1};
      dut_if.start = 1'b0;
      dut_if.signed_div = 1'b0;
      dut_if.annul = 1'b0;
      dut_if.opdata1 = '0;
      dut_if.opdata2 = '0;
      resetn = 1'b0;
      #12;
      check("reset_busy", 64'(dut_if.busy), 64'd0);
      check("reset_ready", 64'(dut_if.ready), 64'd0);
      check("reset_result", dut_if.result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 12; i++)
         run_op(v[i].sdiv, v[i].a, v[i].b, v[i].res, lat_of(v[i].b, v[i].fast), i == 0);
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = 32'($urandom_range(1, 1000));
         run_op(1'b0, a, b, {a % b, a / b}, lat_of(b, a < b), 1'b0);
      end
      // annul part-way through 100/7: no ready, then a clean 50/5
      r0 = ready_seen;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.signed_div = 1'b0;
      dut_if.opdata1 = 32'd100;
      dut_if.opdata2 = 32'd7;
      @(posedge clk);
      #1 dut_if.start = 1'b0;
      repeat (9) @(posedge clk);
      #1 dut_if.annul = 1'b1;
      @(posedge clk);
      #1 dut_if.annul = 1'b0;
      repeat (40) @(posedge clk);
      #1 check("annul_no_ready", 64'(ready_seen), 64'(r0));
      check("annul_busy_low", 64'(dut_if.busy), 64'd0);
      run_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b0);
      // asynchronous reset between edges while a divide is in flight
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.opdata1 = 32'd100;
      dut_if.opdata2 = 32'd7;
      @(posedge clk);
      #1 dut_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check("async_busy", 64'(dut_if.busy), 64'd0);
      check("async_ready", 64'(dut_if.ready), 64'd0);
      check("async_result", dut_if.result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
      run_op(1'b0, 32'd3, 32'd9, {32'd3, 32'd0}, lat_of(32'd9, 1'b1), 1'b0);
      repeat (3) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
